esm_multi_issue_core: RTL and testbench

//  Out-of-order issue window for the ESM datapath; generalises the single-issue core to ISSUE_W issues/cycle.

---
 rtl/esm_pkg.sv | 16 +
 rtl/esm_multi_issue_core_if.sv | 35 +++
 rtl/esm_oldest_select.sv | 33 +++
 rtl/esm_multi_issue_core.sv | 164 ++++++++++++++++
 tb/tb_esm_multi_issue_core.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/esm_pkg.sv
// Shared definitions for the ESM multi-issue window:
// instruction field positions and slot state encoding.
package esm_pkg;

    localparam int RD_LSB  = 7;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        WAIT   = 2'd1,
        ISSUED = 2'd2,
        DONE   = 2'd3
    } slot_state_t;

endpackage

// File: rtl/esm_multi_issue_core_if.sv
// Front-end, issue-lane and completion signals of the issue window.
// master = surrounding pipeline, slave = the window itself.
interface esm_multi_issue_core_if #(
    parameter int Instr_word_size = 32,
    parameter int bs              = 16,
    parameter int ISSUE_W         = 2
);
    localparam int BSB = $clog2(bs);

    logic                       start;
    logic                       in_valid;
    logic                       in_ready;
    logic [Instr_word_size-1:0] Instr_in;
    logic                       ALUSrc;
    logic                       RegWrite;
    logic                       issue_ready;
    logic [ISSUE_W-1:0]         issue_valid;
    logic [ISSUE_W*BSB-1:0]     issue_index;
    logic                       cmpl_valid;
    logic [BSB-1:0]             cmpl_index;
    logic [BSB:0]               count;

    modport master (
        output start, in_valid, Instr_in, ALUSrc, RegWrite,
        output issue_ready, cmpl_valid, cmpl_index,
        input  in_ready, issue_valid, issue_index, count
    );

    modport slave (
        input  start, in_valid, Instr_in, ALUSrc, RegWrite,
        input  issue_ready, cmpl_valid, cmpl_index,
        output in_ready, issue_valid, issue_index, count
    );

endinterface

// File: rtl/esm_oldest_select.sv
// Picks up to ISSUE_W ready slots in age order starting at head.
// Lane 0 gets the oldest; unused lanes are left invalid.
module esm_oldest_select #(
    parameter int bs      = 16,
    parameter int ISSUE_W = 2,
    localparam int BSB    = $clog2(bs)
) (
    input  logic [bs-1:0]          ready,
    input  logic [BSB-1:0]         head,
    output logic [ISSUE_W-1:0]     valid,
    output logic [ISSUE_W*BSB-1:0] index
);

    int             n;
    logic [BSB-1:0] idx;

    // Walk slots from head (oldest) and fill lanes in order.
    always_comb begin
        valid = '0;
        index = '0;
        n     = 0;
        idx   = '0;
        for (int i = 0; i < bs; i++) begin
            idx = head + BSB'(i);
            if (ready[idx] && n < ISSUE_W) begin
                valid[n]             = 1'b1;
                index[n*BSB +: BSB]  = idx;
                n                    = n + 1;
            end
        end
    end

endmodule

// File: rtl/esm_multi_issue_core.sv
// Age-ordered out-of-order issue window: hazard tracking,
// multi-lane oldest-first issue, out-of-order complete, in-order retire.
module esm_multi_issue_core
    import esm_pkg::*;
#(
    parameter int Instr_word_size = 32,
    parameter int regnum          = 32,
    parameter int bs              = 16,
    parameter int ISSUE_W         = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    esm_multi_issue_core_if.slave bus
);

    localparam int BSB = $clog2(bs);
    localparam int RW  = $clog2(regnum);
    localparam logic [BSB:0] FULL = (BSB+1)'(bs);

    slot_state_t st [bs];
    logic [RW-1:0] rd_q  [bs];
    logic [RW-1:0] rs1_q [bs];
    logic [RW-1:0] rs2_q [bs];
    logic [bs-1:0] wr_q;
    logic [bs-1:0] u1_q;
    logic [bs-1:0] u2_q;

    logic [BSB-1:0] head;
    logic [BSB-1:0] tail;
    logic [BSB:0]   count;
    logic           live;

    logic [Instr_word_size-1:0] instr;
    logic [RW-1:0] rd_in;
    logic [RW-1:0] rs1_in;
    logic [RW-1:0] rs2_in;
    logic          alloc;
    logic          retire;

    logic [BSB-1:0] age [bs];
    logic [bs-1:0]  hz  [bs];
    logic [bs-1:0]  rdy;
    logic [bs-1:0]  cand;
    logic [bs-1:0]  pick;

    logic [ISSUE_W-1:0]     sel_valid;
    logic [ISSUE_W*BSB-1:0] sel_index;

    assign instr  = bus.Instr_in;
    assign rd_in  = instr[RD_LSB  +: RW];
    assign rs1_in = instr[RS1_LSB +: RW];
    assign rs2_in = instr[RS2_LSB +: RW];

    // Accept only from registered occupancy; held off until out of reset.
    assign bus.in_ready = live && (count < FULL);
    assign alloc        = bus.in_valid && bus.in_ready;
    assign retire       = (st[head] == DONE);
    assign bus.count    = count;

    // Age of each slot relative to the current head.
    always_comb begin
        for (int i = 0; i < bs; i++) begin
            age[i] = BSB'(i) - head;
        end
    end

    // Hazard matrix: hz[s][o] set when older in-flight o blocks s.
    always_comb begin
        for (int s = 0; s < bs; s++) begin
            for (int o = 0; o < bs; o++) begin
                hz[s][o] = 1'b0;
                if (age[o] < age[s] &&
                    (st[o] == WAIT || st[o] == ISSUED)) begin
                    hz[s][o] =
                        (wr_q[o] &&
                         ((u1_q[s] && rd_q[o] == rs1_q[s]) ||
                          (u2_q[s] && rd_q[o] == rs2_q[s]))) ||
                        (wr_q[o] && wr_q[s] && rd_q[o] == rd_q[s]) ||
                        (st[o] == WAIT && wr_q[s] &&
                         ((u1_q[o] && rs1_q[o] == rd_q[s]) ||
                          (u2_q[o] && rs2_q[o] == rd_q[s])));
                end
            end
            rdy[s] = (st[s] == WAIT) && !(|hz[s]);
        end
    end

    assign cand = rdy & {bs{bus.start}};

    esm_oldest_select #(
        .bs      (bs),
        .ISSUE_W (ISSUE_W)
    ) u_sel (
        .ready (cand),
        .head  (head),
        .valid (sel_valid),
        .index (sel_index)
    );

    assign bus.issue_valid = sel_valid;
    assign bus.issue_index = sel_index;

    // One-hot mask of slots presented on any lane this cycle.
    always_comb begin
        pick = '0;
        for (int k = 0; k < ISSUE_W; k++) begin
            if (sel_valid[k]) begin
                pick[sel_index[k*BSB +: BSB]] = 1'b1;
            end
        end
    end

    // Head/tail pointers, occupancy and the post-reset enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            live  <= 1'b0;
        end else begin
            live <= 1'b1;
            if (alloc) begin
                tail <= tail + 1'b1;
            end
            if (retire) begin
                head <= head + 1'b1;
            end
            count <= count + (BSB+1)'(alloc) - (BSB+1)'(retire);
        end
    end

    // Per-slot lifecycle; the four events never target the same slot.
    always_ff @(posedge clk) begin
        for (int i = 0; i < bs; i++) begin
            if (rst) begin
                st[i] <= EMPTY;
            end else if (alloc && tail == BSB'(i)) begin
                st[i] <= WAIT;
            end else if (bus.issue_ready && pick[i]) begin
                st[i] <= ISSUED;
            end else if (bus.cmpl_valid && bus.cmpl_index == BSB'(i) &&
                         st[i] == ISSUED) begin
                st[i] <= DONE;
            end else if (retire && head == BSB'(i)) begin
                st[i] <= EMPTY;
            end
        end
    end

    // Operand payload captured at allocation; x0 never participates.
    always_ff @(posedge clk) begin
        for (int i = 0; i < bs; i++) begin
            if (alloc && tail == BSB'(i)) begin
                rd_q[i]  <= rd_in;
                rs1_q[i] <= rs1_in;
                rs2_q[i] <= rs2_in;
                wr_q[i]  <= bus.RegWrite && (rd_in != '0);
                u1_q[i]  <= (rs1_in != '0);
                u2_q[i]  <= !bus.ALUSrc && (rs2_in != '0);
            end
        end
    end

endmodule

// File: tb/tb_esm_multi_issue_core.sv
// Directed bench for esm_multi_issue_core: vector table
// plus hand sequences for fill/wrap and mid-stream reset.
module tb_esm_multi_issue_core;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    esm_multi_issue_core_if bus ();

    esm_multi_issue_core dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        st;
        logic        v;
        logic [31:0] ins;
        logic        alu;
        logic        ir;
        logic        cv;
        logic [3:0]  ci;
        logic [1:0]  e_iv;
        logic [3:0]  e_i0;
        logic [3:0]  e_i1;
        logic [4:0]  e_cnt;
    } vec_t;

    vec_t tbl [$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [31:0] add_i(int rd, int rs1, int rs2);
        return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), 7'h33};
    endfunction

    task automatic row(int st, int v, logic [31:0] ins, int alu,
                       int ir, int cv, int ci,
                       int eiv, int e0, int e1, int ecnt);
        vec_t t;
        t.st    = 1'(st);
        t.v     = 1'(v);
        t.ins   = ins;
        t.alu   = 1'(alu);
        t.ir    = 1'(ir);
        t.cv    = 1'(cv);
        t.ci    = 4'(ci);
        t.e_iv  = 2'(eiv);
        t.e_i0  = 4'(e0);
        t.e_i1  = 4'(e1);
        t.e_cnt = 5'(ecnt);
        tbl.push_back(t);
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.start       = 1'b1;
        bus.in_valid    = 1'b0;
        bus.Instr_in    = '0;
        bus.ALUSrc      = 1'b0;
        bus.RegWrite    = 1'b1;
        bus.issue_ready = 1'b0;
        bus.cmpl_valid  = 1'b0;
        bus.cmpl_index  = '0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_iv", 32'(bus.issue_valid), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 32'(bus.in_ready), 1);

        // independent ADDs, out-of-order completion, in-order retire
        row(1,1,add_i(1,0,0),0, 0,0,0,  0,0,0,0);
        row(1,1,add_i(2,0,0),0, 0,0,0,  1,0,0,1);
        row(1,1,add_i(3,0,0),0, 0,0,0,  3,0,1,2);
        row(1,0,0,0,            1,0,0,  3,0,1,3);
        row(1,0,0,0,            1,0,0,  1,2,0,3);
        row(1,0,0,0,            0,1,2,  0,0,0,3);
        row(1,0,0,0,            0,1,1,  0,0,0,3);
        row(1,0,0,0,            0,1,0,  0,0,0,3);
        row(1,0,0,0,            0,0,0,  0,0,0,3);
        row(1,0,0,0,            0,0,0,  0,0,0,2);
        row(1,0,0,0,            0,1,12, 0,0,0,1);
        row(1,0,0,0,            0,0,0,  0,0,0,0);
        // RAW on x5 held until producer completes
        row(1,1,add_i(5,1,2),0, 1,0,0,  0,0,0,0);
        row(1,1,add_i(6,5,0),0, 1,0,0,  1,3,0,1);
        row(1,0,0,0,            1,0,0,  0,0,0,2);
        row(1,0,0,0,            1,1,4,  0,0,0,2);
        row(1,0,0,0,            1,1,3,  0,0,0,2);
        row(1,0,0,0,            1,0,0,  1,4,0,2);
        row(1,0,0,0,            0,1,4,  0,0,0,1);
        row(1,0,0,0,            0,0,0,  0,0,0,1);
        row(1,0,0,0,            0,0,0,  0,0,0,0);
        // immediate operand and x0 never stall
        row(1,1,add_i(5,1,2),0, 0,0,0,  0,0,0,0);
        row(1,1,add_i(8,1,5),1, 0,0,0,  1,5,0,1);
        row(1,1,add_i(0,3,4),0, 0,0,0,  3,5,6,2);
        row(1,1,add_i(9,0,0),0, 1,0,0,  3,5,6,3);
        row(1,0,0,0,            1,0,0,  3,7,8,4);
        row(1,0,0,0,            0,1,5,  0,0,0,4);
        row(1,0,0,0,            0,1,6,  0,0,0,4);
        row(1,0,0,0,            0,1,7,  0,0,0,3);
        row(1,0,0,0,            0,1,8,  0,0,0,2);
        row(1,0,0,0,            0,0,0,  0,0,0,1);
        row(1,0,0,0,            0,0,0,  0,0,0,0);
        // WAR and WAW blocking, start gating
        row(1,1,add_i(10,11,0),0, 0,0,0, 0,0,0,0);
        row(1,1,add_i(11,0,0),0,  0,0,0, 1,9,0,1);
        row(1,1,add_i(10,0,0),0,  0,0,0, 1,9,0,2);
        row(1,0,0,0,              1,0,0, 1,9,0,3);
        row(1,0,0,0,              0,0,0, 1,10,0,3);
        row(0,0,0,0,              0,0,0, 0,0,0,3);
        row(1,0,0,0,              1,1,9, 1,10,0,3);
        row(1,0,0,0,              1,0,0, 1,11,0,3);

        foreach (tbl[r]) begin
            bus.start       = tbl[r].st;
            bus.in_valid    = tbl[r].v;
            bus.Instr_in    = tbl[r].ins;
            bus.ALUSrc      = tbl[r].alu;
            bus.RegWrite    = 1'b1;
            bus.issue_ready = tbl[r].ir;
            bus.cmpl_valid  = tbl[r].cv;
            bus.cmpl_index  = tbl[r].ci;
            #1;
            chk($sformatf("r%0d_count", r),
                32'(bus.count), 32'(tbl[r].e_cnt));
            chk($sformatf("r%0d_in_ready", r), 32'(bus.in_ready), 1);
            chk($sformatf("r%0d_iv", r),
                32'(bus.issue_valid), 32'(tbl[r].e_iv));
            if (tbl[r].e_iv[0])
                chk($sformatf("r%0d_lane0", r),
                    32'(bus.issue_index[3:0]), 32'(tbl[r].e_i0));
            if (tbl[r].e_iv[1])
                chk($sformatf("r%0d_lane1", r),
                    32'(bus.issue_index[7:4]), 32'(tbl[r].e_i1));
            @(posedge clk);
            #1;
        end

        // reset with entries in flight
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_count", 32'(bus.count), 0);
        chk("mid_rst_iv", 32'(bus.issue_valid), 0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_after_ready", 32'(bus.in_ready), 1);
        chk("mid_rst_after_iv", 32'(bus.issue_valid), 0);

        // fill the window, then free one slot and wrap tail
        bus.in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.Instr_in = add_i(i + 1, 0, 0);
            #1;
            chk($sformatf("fill%0d_ready", i), 32'(bus.in_ready), 1);
            @(posedge clk);
            #1;
        end
        bus.Instr_in = add_i(25, 0, 0);
        #1;
        chk("full_count", 32'(bus.count), 16);
        chk("full_in_ready", 32'(bus.in_ready), 0);
        @(posedge clk);
        #1;
        chk("full_blocked_count", 32'(bus.count), 16);
        bus.in_valid    = 1'b0;
        bus.issue_ready = 1'b1;
        #1;
        chk("full_iv", 32'(bus.issue_valid), 3);
        chk("full_lane0", 32'(bus.issue_index[3:0]), 0);
        chk("full_lane1", 32'(bus.issue_index[7:4]), 1);
        @(posedge clk);
        #1;
        bus.issue_ready = 1'b0;
        bus.cmpl_valid  = 1'b1;
        bus.cmpl_index  = 4'd0;
        @(posedge clk);
        #1;
        bus.cmpl_valid = 1'b0;
        #1;
        chk("retire_cycle_in_ready", 32'(bus.in_ready), 0);
        @(posedge clk);
        #1;
        chk("after_retire_count", 32'(bus.count), 15);
        chk("after_retire_in_ready", 32'(bus.in_ready), 1);
        bus.in_valid = 1'b1;
        bus.Instr_in = add_i(20, 0, 0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("wrap_count", 32'(bus.count), 16);
        chk("wrap_in_ready", 32'(bus.in_ready), 0);
        bus.issue_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            #1;
            chk($sformatf("drain%0d_iv", k), 32'(bus.issue_valid), 3);
            chk($sformatf("drain%0d_lane0", k),
                32'(bus.issue_index[3:0]), 32'(2 + 2 * k));
            chk($sformatf("drain%0d_lane1", k),
                32'(bus.issue_index[7:4]), 32'(3 + 2 * k));
            @(posedge clk);
            #1;
        end
        #1;
        chk("wrap_slot_iv", 32'(bus.issue_valid), 1);
        chk("wrap_slot_lane0", 32'(bus.issue_index[3:0]), 0);
        @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
